logic_unit_pipe: RTL and testbench

Parametrised, pipelined successor to the combinational basic-gate set. It applies one of eight selectable bitwise gate functions to two WIDTH-bit operands, with valid/ready handshakes on both sides and a 2-stage pipeline. An optional accumulator can replace operand A with the previous result. Registered zero and parity flags and a transaction counter are provided for downstream status/debug logic.

---
 rtl/logic_unit_pipe.sv | 165 ++++++++++++++++
 tb/tb_logic_unit_pipe.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready pipeline applying one of eight bitwise gate functions,
// with optional result accumulator, registered zero/parity flags and a handshake counter.
module logic_unit_pipe #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned ACC_EN = 1,
    parameter int unsigned CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [2:0]       op,
    input  logic             acc,
    input  logic             acc_clr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] y,
    output logic             zero,
    output logic             parity,
    output logic [CNT_W-1:0] txn_count
);

    typedef enum logic [2:0] {
        OP_AND   = 3'b000,
        OP_OR    = 3'b001,
        OP_NAND  = 3'b010,
        OP_NOR   = 3'b011,
        OP_NOTA  = 3'b100,
        OP_XOR   = 3'b101,
        OP_XNOR  = 3'b110,
        OP_PASSB = 3'b111
    } op_e;

    // Stage 1 registers
    logic             s1_valid_q, s1_valid_d;
    logic [WIDTH-1:0] s1_a_q, s1_a_d;
    logic [WIDTH-1:0] s1_b_q, s1_b_d;
    op_e              s1_op_q, s1_op_d;
    logic             s1_acc_q, s1_acc_d;

    // Stage 2 / output registers
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic             zero_q, zero_d;
    logic             parity_q, parity_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic             s2_load;
    logic             in_hs;
    logic             out_hs;
    logic [WIDTH-1:0] eff_a;
    logic [WIDTH-1:0] result;

    assign s2_load  = s1_valid_q & (~out_valid_q | out_ready);
    assign in_ready = ~rst & (~s1_valid_q | s2_load);
    assign in_hs    = in_valid & in_ready;
    assign out_hs   = out_valid_q & out_ready;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_a_d     = s1_a_q;
        s1_b_d     = s1_b_q;
        s1_op_d    = s1_op_q;
        s1_acc_d   = s1_acc_q;
        if (in_hs) begin
            s1_valid_d = 1'b1;
            s1_a_d     = a;
            s1_b_d     = b;
            s1_op_d    = op_e'(op);
            s1_acc_d   = (ACC_EN != 0) ? acc : 1'b0;
        end else if (s2_load) begin
            s1_valid_d = 1'b0;
        end
    end

    // A same-cycle clear is visible to the loading transaction as a zero accumulator.
    always_comb begin
        eff_a = s1_a_q;
        if (s1_acc_q) begin
            eff_a = acc_clr ? '0 : acc_q;
        end
    end

    always_comb begin
        result = '0;
        case (s1_op_q)
            OP_AND:   result = eff_a & s1_b_q;
            OP_OR:    result = eff_a | s1_b_q;
            OP_NAND:  result = ~(eff_a & s1_b_q);
            OP_NOR:   result = ~(eff_a | s1_b_q);
            OP_NOTA:  result = ~eff_a;
            OP_XOR:   result = eff_a ^ s1_b_q;
            OP_XNOR:  result = ~(eff_a ^ s1_b_q);
            OP_PASSB: result = s1_b_q;
            default:  result = '0;
        endcase
    end

    always_comb begin
        out_valid_d = out_valid_q;
        y_d         = y_q;
        zero_d      = zero_q;
        parity_d    = parity_q;
        acc_d       = '0;
        cnt_d       = cnt_q;
        if (s2_load) begin
            out_valid_d = 1'b1;
            y_d         = result;
            zero_d      = (result == '0);
            parity_d    = ^result;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
        // Load write takes priority over a clear in the same cycle.
        if (ACC_EN != 0) begin
            acc_d = acc_q;
            if (s2_load) begin
                acc_d = result;
            end else if (acc_clr) begin
                acc_d = '0;
            end
        end
        if (out_hs) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_op_q     <= OP_AND;
            s1_acc_q    <= 1'b0;
            out_valid_q <= 1'b0;
            y_q         <= '0;
            zero_q      <= 1'b0;
            parity_q    <= 1'b0;
            acc_q       <= '0;
            cnt_q       <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_op_q     <= s1_op_d;
            s1_acc_q    <= s1_acc_d;
            out_valid_q <= out_valid_d;
            y_q         <= y_d;
            zero_q      <= zero_d;
            parity_q    <= parity_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign y         = y_q;
    assign zero      = zero_q;
    assign parity    = parity_q;
    assign txn_count = cnt_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Bench for logic_unit_pipe: vector tables, backpressure/reset/accumulator sequences,
// and a randomized run scored against an in-order reference model.
module tb_logic_unit_pipe;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic [2:0] op = '0;
    logic       acc = 1'b0;
    logic       acc_clr = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] y;
    logic       zero;
    logic       parity;
    logic [7:0] txn_count;

    int unsigned n_pass = 0;
    int unsigned n_total = 0;

    always #5 clk = ~clk;

    logic_unit_pipe #(.WIDTH(8), .ACC_EN(1), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .op(op), .acc(acc), .acc_clr(acc_clr),
        .out_valid(out_valid), .out_ready(out_ready), .y(y), .zero(zero),
        .parity(parity), .txn_count(txn_count)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic [2:0] op;
        logic       acc;
        logic       clr;
        logic [7:0] y;
        logic       z;
        logic       p;
    } vec_t;

    vec_t vt[19];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        else n_pass++;
    endtask

    task automatic fail(input string nm);
        n_total++;
        $display("FAIL %s: event not observed as required", nm);
    endtask

    task automatic setv(input int i, input logic [7:0] va, input logic [7:0] vb,
                        input logic [2:0] vop, input logic vacc, input logic vclr,
                        input logic [7:0] vy, input logic vz, input logic vp);
        vt[i].a = va; vt[i].b = vb; vt[i].op = vop; vt[i].acc = vacc;
        vt[i].clr = vclr; vt[i].y = vy; vt[i].z = vz; vt[i].p = vp;
    endtask

    function automatic logic [7:0] gate(input logic [2:0] f, input logic [7:0] x, input logic [7:0] w);
        case (f)
            3'd0: return x & w;
            3'd1: return x | w;
            3'd2: return ~(x & w);
            3'd3: return ~(x | w);
            3'd4: return ~x;
            3'd5: return x ^ w;
            3'd6: return ~(x ^ w);
            default: return w;
        endcase
    endfunction

    task automatic drive(input int i);
        a = vt[i].a; b = vt[i].b; op = vt[i].op; acc = vt[i].acc;
        acc_clr = vt[i].clr; in_valid = 1'b1;
    endtask

    // Streams n records back-to-back with out_ready high; each result is due two cycles later.
    task automatic stream(input int first, input int n, input int base);
        for (int i = 0; i < n + 2; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                chk("stream_valid", out_valid, 1);
                chk("stream_y", y, vt[first + i - 2].y);
                chk("stream_zero", zero, vt[first + i - 2].z);
                chk("stream_parity", parity, vt[first + i - 2].p);
                chk("stream_count", txn_count, base + i - 2);
            end
            if (i < n) begin
                chk("stream_in_ready", in_ready, 1);
                drive(first + i);
            end else begin
                in_valid = 1'b0;
                acc_clr = 1'b0;
                acc = 1'b0;
            end
        end
        @(negedge clk);
        chk("stream_drained", out_valid, 0);
        chk("stream_count_end", txn_count, base + n);
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] accm;
        logic [7:0] e;
        logic [7:0] r;
        int issued, done, cyc;

        setv(0,  8'hF0, 8'h3C, 3'd0, 0, 0, 8'h30, 0, 0);
        setv(1,  8'hF0, 8'h3C, 3'd1, 0, 0, 8'hFC, 0, 0);
        setv(2,  8'hF0, 8'h3C, 3'd2, 0, 0, 8'hCF, 0, 0);
        setv(3,  8'hF0, 8'h3C, 3'd3, 0, 0, 8'h03, 0, 0);
        setv(4,  8'hF0, 8'h3C, 3'd4, 0, 0, 8'h0F, 0, 0);
        setv(5,  8'hF0, 8'h3C, 3'd5, 0, 0, 8'hCC, 0, 0);
        setv(6,  8'hF0, 8'h3C, 3'd6, 0, 0, 8'h33, 0, 0);
        setv(7,  8'hF0, 8'h3C, 3'd7, 0, 0, 8'h3C, 0, 0);
        setv(8,  8'hAA, 8'h55, 3'd0, 0, 0, 8'h00, 1, 0);
        setv(9,  8'hAA, 8'h55, 3'd1, 0, 0, 8'hFF, 0, 0);
        setv(10, 8'h01, 8'h00, 3'd1, 0, 0, 8'h01, 0, 1);
        setv(11, 8'hFF, 8'h01, 3'd1, 1, 1, 8'h01, 0, 1);
        setv(12, 8'hFF, 8'h02, 3'd1, 1, 0, 8'h03, 0, 0);
        setv(13, 8'hFF, 8'h04, 3'd1, 1, 0, 8'h07, 0, 1);
        setv(14, 8'hFF, 8'h80, 3'd1, 1, 0, 8'h87, 0, 0);
        setv(15, 8'hFF, 8'h01, 3'd1, 1, 1, 8'h01, 0, 1);
        setv(16, 8'hFF, 8'h02, 3'd1, 1, 0, 8'h03, 0, 0);
        setv(17, 8'hFF, 8'h04, 3'd1, 1, 0, 8'h04, 0, 1);
        setv(18, 8'hFF, 8'h80, 3'd1, 1, 1, 8'h84, 0, 0);

        // Reset state
        #1;
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_y", y, 0);
        chk("rst_zero", zero, 0);
        chk("rst_parity", parity, 0);
        chk("rst_count", txn_count, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        #1 chk("release_in_ready", in_ready, 1);

        stream(0, 11, 0);
        stream(11, 4, 11);
        stream(15, 4, 15);

        // Backpressure: two accepted, third stalls, first result holds
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_ready0", in_ready, 1);
        drive(0);
        @(negedge clk);
        chk("bp_ready1", in_ready, 1);
        drive(1);
        @(negedge clk);
        chk("bp_valid", out_valid, 1);
        chk("bp_y_first", y, vt[0].y);
        chk("bp_ready_low", in_ready, 0);
        drive(2);
        repeat (3) begin
            @(negedge clk);
            chk("bp_hold_valid", out_valid, 1);
            chk("bp_hold_y", y, vt[0].y);
            chk("bp_hold_ready", in_ready, 0);
            chk("bp_hold_count", txn_count, 19);
        end
        @(negedge clk);
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", in_ready, 1);
        chk("bp_release_y", y, vt[0].y);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_y_second", y, vt[1].y);
        chk("bp_valid_second", out_valid, 1);
        @(negedge clk);
        chk("bp_y_third", y, vt[2].y);
        chk("bp_valid_third", out_valid, 1);
        @(negedge clk);
        chk("bp_drained", out_valid, 0);
        chk("bp_count", txn_count, 22);

        // Reset with two transactions in flight
        @(negedge clk);
        drive(5);
        @(negedge clk);
        drive(6);
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b0;
        chk("mid_valid_before", out_valid, 1);
        #1 rst = 1'b1;
        #1;
        chk("mid_valid_async", out_valid, 0);
        chk("mid_y", y, 0);
        chk("mid_count", txn_count, 0);
        chk("mid_in_ready", in_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        #1 chk("mid_release_ready", in_ready, 1);
        repeat (4) begin
            @(negedge clk);
            chk("mid_no_emit", out_valid, 0);
        end
        chk("mid_count_after", txn_count, 0);

        // Randomized traffic scored against an in-order model; 255 handshakes sets up the wrap
        accm = '0;
        issued = 0;
        done = 0;
        cyc = 0;
        while ((issued < 255 || done < issued) && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            out_ready = ($urandom_range(0, 3) != 0);
            if (issued < 255 && $urandom_range(0, 3) != 0) begin
                in_valid = 1'b1;
                a = 8'($urandom);
                b = 8'($urandom);
                op = 3'($urandom_range(0, 7));
                acc = 1'($urandom_range(0, 1));
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    fail("rand_spurious_output");
                end else begin
                    e = q.pop_front();
                    chk("rand_y", y, e);
                    chk("rand_zero", zero, (e == 8'h00));
                    chk("rand_parity", parity, $countones(e) % 2);
                    chk("rand_count", txn_count, done);
                    done++;
                end
            end
            if (in_valid && in_ready) begin
                r = gate(op, acc ? accm : a, b);
                accm = r;
                q.push_back(r);
                issued++;
            end
        end
        if (cyc >= 3000) fail("rand_timeout");
        in_valid = 1'b0;
        acc = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("wrap_pre_count", txn_count, 255);
        a = 8'h0F; b = 8'hF0; op = 3'd5; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        chk("wrap_y", y, 8'hFF);
        chk("wrap_valid", out_valid, 1);
        @(negedge clk);
        chk("wrap_count", txn_count, 0);
        chk("wrap_drained", out_valid, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
